// File: rtl/conv_pkg.sv
// Shared definitions for the convolution B-bus sequencer.
// Holds the B-bus mux select codes and the sequencer state encoding.
package conv_pkg;

  localparam int unsigned SEL_CODE_W = 5;

  // B-bus mux select codes
  localparam logic [SEL_CODE_W-1:0] SEL_MDR  = 5'd0;
  localparam logic [SEL_CODE_W-1:0] SEL_K0   = 5'd1;
  localparam logic [SEL_CODE_W-1:0] SEL_K1   = 5'd2;
  localparam logic [SEL_CODE_W-1:0] SEL_K2   = 5'd3;
  localparam logic [SEL_CODE_W-1:0] SEL_K3   = 5'd4;
  localparam logic [SEL_CODE_W-1:0] SEL_K4   = 5'd5;
  localparam logic [SEL_CODE_W-1:0] SEL_K5   = 5'd6;
  localparam logic [SEL_CODE_W-1:0] SEL_K6   = 5'd7;
  localparam logic [SEL_CODE_W-1:0] SEL_K7   = 5'd8;
  localparam logic [SEL_CODE_W-1:0] SEL_K8   = 5'd9;
  localparam logic [SEL_CODE_W-1:0] SEL_P1   = 5'd10;
  localparam logic [SEL_CODE_W-1:0] SEL_P2   = 5'd11;
  localparam logic [SEL_CODE_W-1:0] SEL_P3   = 5'd12;
  localparam logic [SEL_CODE_W-1:0] SEL_DP   = 5'd13;
  localparam logic [SEL_CODE_W-1:0] SEL_CV   = 5'd14;
  localparam logic [SEL_CODE_W-1:0] SEL_I    = 5'd15;
  localparam logic [SEL_CODE_W-1:0] SEL_MBRU = 5'd16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_FETCH  = 3'd2,
    ST_PIX    = 3'd3,
    ST_KER    = 3'd4,
    ST_RESULT = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } state_t;

endpackage

// File: rtl/conv_tap_counter.sv
// Kernel tap index counter with clear, saturating increment and last-tap flag.
// Ports: clk, reset (sync, active-high), clr, inc -> idx (current tap), last (idx==NTAPS-1).
module conv_tap_counter #(
  parameter int unsigned NTAPS = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] idx,
  output logic       last
);

  assign last = (idx == 4'(NTAPS - 1));

  // Increment saturates at the last tap so the index never wraps
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      idx <= 4'd0;
    end else if (inc && !last) begin
      idx <= idx + 4'd1;
    end
  end

endmodule

// File: rtl/conv_bbus_sequencer.sv
// Sequences the B-bus mux and MAC enables through one 3x3 convolution window.
// Inputs : clk, reset (sync, active-high), start, abort, mem_ack.
// Outputs: mem_req, tap_idx, bbus_sel, mdr_ld, acc_clr, pix_ld, mac_en, res_we,
//          busy, done, err. All outputs are registered except mdr_ld, which
//          follows mem_ack while a fetch is outstanding.
module conv_bbus_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned NTAPS   = 9,
  parameter int unsigned SEL_W   = 5,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic [3:0]       tap_idx,
  output logic [SEL_W-1:0] bbus_sel,
  output logic             mdr_ld,
  output logic             acc_clr,
  output logic             pix_ld,
  output logic             mac_en,
  output logic             res_we,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] to_cnt;
  logic             tap_last;
  logic             tap_clr;
  logic             tap_inc;

  conv_tap_counter #(.NTAPS(NTAPS)) u_tap (
    .clk   (clk),
    .reset (reset),
    .clr   (tap_clr),
    .inc   (tap_inc),
    .idx   (tap_idx),
    .last  (tap_last)
  );

  assign tap_clr = (state == ST_CLR) || (state == ST_ERR);
  assign tap_inc = (state == ST_KER) && (state_nxt == ST_FETCH);

  // MDR loads in the same cycle the memory acknowledges
  assign mdr_ld = mem_req & mem_ack;

  // Next-state logic; abort overrides everything in the abortable states
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_CLR;
      ST_CLR:    state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (mem_ack)                           state_nxt = ST_PIX;
        else if (to_cnt == CNT_W'(TIMEOUT - 1)) state_nxt = ST_ERR;
      end
      ST_PIX:    state_nxt = ST_KER;
      ST_KER:    state_nxt = tap_last ? ST_RESULT : ST_FETCH;
      ST_RESULT: state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      ST_ERR:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (abort && (state inside {ST_CLR, ST_FETCH, ST_PIX, ST_KER, ST_RESULT})) begin
      state_nxt = ST_ERR;
    end
  end

  // State, timeout counter and Moore outputs decoded from the next state so
  // that each output is valid throughout the cycle of its state
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      to_cnt   <= '0;
      mem_req  <= 1'b0;
      bbus_sel <= SEL_W'(SEL_MDR);
      acc_clr  <= 1'b0;
      pix_ld   <= 1'b0;
      mac_en   <= 1'b0;
      res_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      to_cnt   <= ((state == ST_FETCH) && (state_nxt == ST_FETCH)) ? to_cnt + CNT_W'(1) : '0;
      mem_req  <= (state_nxt == ST_FETCH);
      acc_clr  <= (state_nxt == ST_CLR);
      pix_ld   <= (state_nxt == ST_PIX);
      mac_en   <= (state_nxt == ST_KER);
      res_we   <= (state_nxt == ST_RESULT);
      busy     <= (state_nxt != ST_IDLE);
      done     <= (state_nxt == ST_DONE);
      err      <= (state_nxt == ST_ERR);
      // KER is only entered from PIX, where tap_idx already holds the KER tap
      case (state_nxt)
        ST_KER:    bbus_sel <= SEL_W'(SEL_K0) + SEL_W'(tap_idx);
        ST_RESULT: bbus_sel <= SEL_W'(SEL_CV);
        default:   bbus_sel <= SEL_W'(SEL_MDR);
      endcase
    end
  end

endmodule

// File: tb/tb_conv_bbus_sequencer.sv
// Randomized self-checking bench for conv_bbus_sequencer. A reference model
// builds the expected per-cycle timeline of a window (state kind + tap) and
// the stimulus for each cycle; outputs are compared cycle by cycle.
module tb_conv_bbus_sequencer;

  localparam int NT = 9;
  localparam int TO = 64;

  localparam int K_IDLE = 0, K_CLR = 1, K_FETCH = 2, K_PIX = 3;
  localparam int K_KER = 4, K_RESULT = 5, K_DONE = 6, K_ERR = 7;

  localparam int M_ZERO = 0, M_RAND = 1, M_ABORT = 2, M_TIMEOUT = 3;
  localparam int M_RESET = 4, M_TAP4 = 5;

  logic       clk = 1'b0;
  logic       reset, start, abort, mem_ack;
  logic       mem_req, mdr_ld, acc_clr, pix_ld, mac_en, res_we, busy, done, err;
  logic [3:0] tap_idx;
  logic [4:0] bbus_sel;
  logic [18:0] act;

  int checks = 0;
  int errors = 0;
  int cur_tap = 0;

  typedef struct {
    int kind;
    int tap;
    bit start;
    bit abort;
    bit ack;
    bit rst;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  conv_bbus_sequencer #(.NTAPS(NT), .SEL_W(5), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mem_ack(mem_ack),
    .mem_req(mem_req), .tap_idx(tap_idx), .bbus_sel(bbus_sel), .mdr_ld(mdr_ld),
    .acc_clr(acc_clr), .pix_ld(pix_ld), .mac_en(mac_en), .res_we(res_we),
    .busy(busy), .done(done), .err(err)
  );

  assign act = {tap_idx, bbus_sel, mem_req, mdr_ld, acc_clr, pix_ld, mac_en,
                res_we, busy, done, err};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected output word for one cycle spent in a given kind of state
  function automatic logic [18:0] mk(input int kind, input int tap, input bit ack);
    logic [4:0] sel;
    bit req, mdr, clr, pix, mac, we, bsy, dn, er;
    sel = 5'd0; req = 0; mdr = 0; clr = 0; pix = 0; mac = 0; we = 0;
    bsy = (kind != K_IDLE); dn = 0; er = 0;
    case (kind)
      K_CLR:    clr = 1;
      K_FETCH:  begin req = 1; mdr = ack; end
      K_PIX:    pix = 1;
      K_KER:    begin sel = 5'(1 + tap); mac = 1; end
      K_RESULT: begin sel = 5'd14; we = 1; end
      K_DONE:   dn = 1;
      K_ERR:    er = 1;
      default:  ;
    endcase
    return {4'(tap), sel, req, mdr, clr, pix, mac, we, bsy, dn, er};
  endfunction

  // Append one cycle; start/abort/ack are randomized where they must be ignored
  task automatic push(input int kind, input int tap, input bit ack);
    ent_t e;
    e.kind  = kind;
    e.tap   = tap;
    e.start = (kind != K_IDLE) ? 1'($urandom_range(0, 1)) : 1'b0;
    e.abort = (kind == K_DONE || kind == K_ERR) ? 1'($urandom_range(0, 1)) : 1'b0;
    e.ack   = (kind == K_FETCH) ? ack : 1'($urandom_range(0, 1));
    e.rst   = 1'b0;
    q.push_back(e);
  endtask

  task automatic run_window(input int mode, input string name);
    int waits[NT];
    int sum_w, to_tap, d, i, tap_e, done_cyc, macs;
    bit timed_out;
    q.delete();
    sum_w = 0;
    timed_out = 0;
    to_tap = $urandom_range(0, NT - 1);
    for (int k = 0; k < NT; k++) begin
      waits[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      if (mode == M_ZERO || mode == M_TAP4) waits[k] = 0;
      if (mode == M_TAP4 && k == 4) waits[k] = 3;
      sum_w += waits[k];
    end

    push(K_IDLE, cur_tap, 0);
    q[0].start = 1'b1;
    q[0].abort = 1'($urandom_range(0, 1));
    push(K_CLR, cur_tap, 0);
    for (int k = 0; k < NT && !timed_out; k++) begin
      if (mode == M_TIMEOUT && k == to_tap) begin
        for (int w = 0; w < TO; w++) push(K_FETCH, k, 0);
        push(K_ERR, k, 0);
        push(K_IDLE, 0, 0);
        timed_out = 1;
      end else begin
        for (int w = 0; w <= waits[k]; w++) push(K_FETCH, k, w == waits[k]);
        push(K_PIX, k, 0);
        push(K_KER, k, 0);
      end
    end
    if (!timed_out) begin
      push(K_RESULT, NT - 1, 0);
      push(K_DONE, NT - 1, 0);
      push(K_IDLE, NT - 1, 0);
    end

    if (mode == M_ABORT) begin
      d = q.size() - 2;
      i = $urandom_range(1, d - 1);
      q[i].abort = 1'b1;
      tap_e = (q[i].kind == K_CLR) ? 0 : q[i].tap;
      while (q.size() > i + 1) void'(q.pop_back());
      push(K_ERR, tap_e, 0);
      push(K_IDLE, 0, 0);
    end else if (mode == M_RESET) begin
      i = $urandom_range(1, q.size() - 3);
      q[i].rst = 1'b1;
      while (q.size() > i + 1) void'(q.pop_back());
      push(K_IDLE, 0, 0);
    end

    done_cyc = -1;
    macs = 0;
    for (int c = 0; c < q.size(); c++) begin
      @(negedge clk);
      reset   = q[c].rst;
      start   = q[c].start;
      abort   = q[c].abort;
      mem_ack = q[c].ack;
      #1;
      check($sformatf("%s_c%0d", name, c), 32'(act), 32'(mk(q[c].kind, q[c].tap, q[c].ack)));
      if (done && done_cyc < 0) done_cyc = c;
      if (mac_en) macs++;
    end
    if (mode == M_ZERO || mode == M_RAND || mode == M_TAP4) begin
      check({name, "_done_cycle"}, 32'(done_cyc), 32'(2 + 3 * NT + sum_w + 1));
      check({name, "_mac_count"}, 32'(macs), 32'(NT));
    end else if (mode == M_TIMEOUT) begin
      check({name, "_mac_count"}, 32'(macs), 32'(to_tap));
    end
    cur_tap = q[q.size() - 1].tap;
    reset = 0; start = 0; abort = 0; mem_ack = 0;
  endtask

  initial begin
    reset = 1; start = 0; abort = 0; mem_ack = 0;
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", 32'(act), 32'(19'd0));
    reset = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_ack = 1'($urandom_range(0, 1));
      abort   = 1'($urandom_range(0, 1));
      #1 check($sformatf("idle_hold_%0d", c), 32'(act), 32'(19'd0));
    end
    cur_tap = 0;

    run_window(M_ZERO,    "zero_wait");
    run_window(M_TAP4,    "tap4_wait");
    run_window(M_TIMEOUT, "timeout");
    run_window(M_ZERO,    "after_timeout");
    run_window(M_ABORT,   "abort");
    run_window(M_RESET,   "reset_mid");
    for (int r = 0; r < 24; r++) begin
      run_window(r % 4 == 3 ? M_RESET : (r % 4 == 2 ? M_ABORT : M_RAND),
                 $sformatf("rand%0d", r));
    end
    run_window(M_TIMEOUT, "timeout2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
